onchip_sram_dp_avalon: RTL and testbench

//   Parametrised true-dual-port on-chip SRAM with two Avalon-MM slave ports (s1, s2).

---
 rtl/onchip_mem_pkg.sv | 32 +++
 rtl/onchip_sram_dp_avalon_if.sv | 25 ++
 rtl/onchip_ram_tdp_core.sv | 44 ++++
 rtl/onchip_sram_dp_avalon.sv | 114 +++++++++++
 tb/tb_onchip_sram_dp_avalon.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared constants and helpers for the on-chip memory family: latency bounds,
// a constant-evaluable clog2 and a byte-lane merge used by the RAM core.
package onchip_mem_pkg;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;
  localparam int MAX_DATA_W       = 256;
  localparam int MAX_BE_W         = MAX_DATA_W / 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Lanes with be=1 take new_word, the rest keep old_word; callers zero-extend
  // narrower words to MAX_DATA_W and truncate the result back.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) r[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/onchip_sram_dp_avalon_if.sv
// One Avalon-MM slave port of the dual-port SRAM (pipelined reads with readdatavalid).
interface onchip_sram_dp_avalon_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_ram_tdp_core.sv
// Inferred true-dual-port RAM with per-port byte enables and registered read-first
// outputs (mixed-port reads see old data).
module onchip_ram_tdp_core
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                a_rd,
  input  logic                a_wr,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_rd,
  input  logic                b_wr,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports write from one process; same-address double writes never reach here.
  always_ff @(posedge clk) begin
    if (a_wr) mem[a_addr] <= DATA_W'(byte_merge(MAX_DATA_W'(mem[a_addr]), MAX_DATA_W'(a_wdata), MAX_BE_W'(a_be)));
    if (b_wr) mem[b_addr] <= DATA_W'(byte_merge(MAX_DATA_W'(mem[b_addr]), MAX_DATA_W'(b_wdata), MAX_BE_W'(b_be)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_rd) a_rdata <= mem[a_addr];
      if (b_rd) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/onchip_sram_dp_avalon.sv
// Dual-port Avalon-MM on-chip SRAM: write-collision arbitration, stall gating
// and per-port read-valid pipeline around the true-dual-port RAM core.
module onchip_sram_dp_avalon
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clken,
  input  logic reset_req,
  onchip_sram_dp_avalon_if.slave s1,
  onchip_sram_dp_avalon_if.slave s2
);
  localparam bit OUT_REG = (READ_LATENCY >= READ_LATENCY_MAX);

  logic              ready;
  logic              stall;
  logic              collide;
  logic              s1_wait;
  logic              s2_wait;
  logic [1:0]        rd_acc;
  logic [1:0]        wr_acc;
  logic [1:0]        vld_p1;
  logic [1:0]        rdv;
  logic [DATA_W-1:0] s1_q_p1;
  logic [DATA_W-1:0] s2_q_p1;

  assign stall   = ~clken | reset_req;
  // Same-address double write: s1 wins, s2 is held off for this cycle only.
  assign collide = s1.chipselect & s1.write & s2.chipselect & s2.write &
                   (s1.address == s2.address);
  assign s1_wait = ~ready | stall;
  assign s2_wait = ~ready | stall | collide;

  assign s1.waitrequest = s1_wait;
  assign s2.waitrequest = s2_wait;

  // Read and write together counts as a write only.
  assign wr_acc[0] = s1.chipselect & s1.write & ~s1_wait;
  assign rd_acc[0] = s1.chipselect & s1.read & ~s1.write & ~s1_wait;
  assign wr_acc[1] = s2.chipselect & s2.write & ~s2_wait;
  assign rd_acc[1] = s2.chipselect & s2.read & ~s2.write & ~s2_wait;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready <= 1'b0;
    else          ready <= 1'b1;
  end

  onchip_ram_tdp_core #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .a_rd    (rd_acc[0]),
    .a_wr    (wr_acc[0]),
    .a_addr  (s1.address),
    .a_be    (s1.byteenable),
    .a_wdata (s1.writedata),
    .a_rdata (s1_q_p1),
    .b_rd    (rd_acc[1]),
    .b_wr    (wr_acc[1]),
    .b_addr  (s2.address),
    .b_be    (s2.byteenable),
    .b_wdata (s2.writedata),
    .b_rdata (s2_q_p1)
  );

  // Stage p1: RAM output register; valid advances only on non-stalled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    vld_p1 <= 2'b00;
    else if (!stall) vld_p1 <= rd_acc;
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [1:0]        vld_p2;
      logic [DATA_W-1:0] s1_data_p2;
      logic [DATA_W-1:0] s2_data_p2;

      // Stage p2: optional output register, frozen together with p1 on stall.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_p2     <= 2'b00;
          s1_data_p2 <= '0;
          s2_data_p2 <= '0;
        end else if (!stall) begin
          vld_p2 <= vld_p1;
          if (vld_p1[0]) s1_data_p2 <= s1_q_p1;
          if (vld_p1[1]) s2_data_p2 <= s2_q_p1;
        end
      end

      assign rdv         = vld_p2 & {2{~stall}};
      assign s1.readdata = s1_data_p2;
      assign s2.readdata = s2_data_p2;
    end else begin : g_no_out_reg
      assign rdv         = vld_p1 & {2{~stall}};
      assign s1.readdata = s1_q_p1;
      assign s2.readdata = s2_q_p1;
    end
  endgenerate

  assign s1.readdatavalid = rdv[0];
  assign s2.readdatavalid = rdv[1];

endmodule

// File: tb/tb_onchip_sram_dp_avalon.sv
// Scoreboard bench: one instance per read latency (1 and 2) fed identical stimulus,
// expected read data taken from a word/byte-level memory model.
module tb_onchip_sram_dp_avalon;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int BE_W   = DATA_W / 8;

  typedef struct {
    logic              cs;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   known;
    int                due;
  } exp_t;

  logic clk       = 1'b0;
  logic reset_n   = 1'b1;
  logic clken     = 1'b1;
  logic reset_req = 1'b0;

  always #5 clk = ~clk;

  onchip_sram_dp_avalon_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) a1 ();
  onchip_sram_dp_avalon_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) a2 ();
  onchip_sram_dp_avalon_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b1 ();
  onchip_sram_dp_avalon_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b2 ();

  assign b1.address    = a1.address;
  assign b1.byteenable = a1.byteenable;
  assign b1.chipselect = a1.chipselect;
  assign b1.read       = a1.read;
  assign b1.write      = a1.write;
  assign b1.writedata  = a1.writedata;
  assign b2.address    = a2.address;
  assign b2.byteenable = a2.byteenable;
  assign b2.chipselect = a2.chipselect;
  assign b2.read       = a2.read;
  assign b2.write      = a2.write;
  assign b2.writedata  = a2.writedata;

  onchip_sram_dp_avalon #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(1), .INIT_FILE("")
  ) dut_l1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .s1(a1), .s2(a2)
  );

  onchip_sram_dp_avalon #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(2), .INIT_FILE("")
  ) dut_l2 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .s1(b1), .s2(b2)
  );

  logic [DATA_W-1:0] mem_m   [DEPTH];
  logic [BE_W-1:0]   known_m [DEPTH];
  exp_t              sb      [4][$];   // index = instance*2 + port
  int                n_checks = 0;
  int                n_fail   = 0;
  int                nsc      = 0;     // count of non-stalled cycles seen by the monitor
  bit                mon_en   = 1'b0;

  function automatic void check(input string name, input int idx,
                                input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endfunction

  function automatic req_t idle();
    req_t r;
    r.cs = 1'b0; r.rd = 1'b0; r.wr = 1'b0; r.addr = '0; r.be = '0; r.wdata = '0;
    return r;
  endfunction

  function automatic req_t rd(input logic [ADDR_W-1:0] addr);
    req_t r;
    r = idle();
    r.cs = 1'b1; r.rd = 1'b1; r.addr = addr;
    return r;
  endfunction

  function automatic req_t wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d,
                              input logic [BE_W-1:0] be);
    req_t r;
    r = idle();
    r.cs = 1'b1; r.wr = 1'b1; r.addr = addr; r.wdata = d; r.be = be;
    return r;
  endfunction

  task automatic drive(input req_t r1, input req_t r2, input logic ck, input logic rq);
    a1.chipselect = r1.cs; a1.read = r1.rd; a1.write = r1.wr;
    a1.address = r1.addr; a1.byteenable = r1.be; a1.writedata = r1.wdata;
    a2.chipselect = r2.cs; a2.read = r2.rd; a2.write = r2.wr;
    a2.address = r2.addr; a2.byteenable = r2.be; a2.writedata = r2.wdata;
    clken = ck;
    reset_req = rq;
  endtask

  task automatic model_write(input req_t r);
    for (int b = 0; b < BE_W; b++) begin
      if (r.be[b]) begin
        mem_m[r.addr][b*8 +: 8] = r.wdata[b*8 +: 8];
        known_m[r.addr][b] = 1'b1;
      end
    end
  endtask

  task automatic push_read(input int port, input logic [ADDR_W-1:0] addr);
    exp_t e;
    e.data  = mem_m[addr];
    e.known = known_m[addr];
    e.due   = nsc + 1;
    sb[port].push_back(e);
    e.due   = nsc + 2;
    sb[2 + port].push_back(e);
  endtask

  // One bus cycle: called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input req_t r1, input req_t r2, input logic ck, input logic rq);
    logic st, w1, w2, acc1, acc2;
    drive(r1, r2, ck, rq);
    @(negedge clk); #1;
    st = ~ck | rq;
    w1 = st;
    w2 = st | (r1.cs & r1.wr & r2.cs & r2.wr & (r1.addr == r2.addr));
    check("s1_waitrequest", 0, 64'(a1.waitrequest), 64'(w1));
    check("s2_waitrequest", 0, 64'(a2.waitrequest), 64'(w2));
    check("s1_waitrequest", 1, 64'(b1.waitrequest), 64'(w1));
    check("s2_waitrequest", 1, 64'(b2.waitrequest), 64'(w2));
    acc1 = r1.cs & (r1.rd | r1.wr) & ~w1;
    acc2 = r2.cs & (r2.rd | r2.wr) & ~w2;
    // Reads observe the memory before this cycle's writes land.
    if (acc1 && r1.rd && !r1.wr) push_read(0, r1.addr);
    if (acc2 && r2.rd && !r2.wr) push_read(1, r2.addr);
    if (acc1 && r1.wr) model_write(r1);
    if (acc2 && r2.wr) model_write(r2);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(idle(), idle(), 1'b1, 1'b0);
  endtask

  task automatic check_held_in_reset(input logic exp_wait);
    check("rst_waitrequest", 0, 64'({a1.waitrequest, a2.waitrequest}), 64'({2{exp_wait}}));
    check("rst_waitrequest", 1, 64'({b1.waitrequest, b2.waitrequest}), 64'({2{exp_wait}}));
    check("rst_readdatavalid", 0, 64'({a1.readdatavalid, a2.readdatavalid}), 64'd0);
    check("rst_readdatavalid", 1, 64'({b1.readdatavalid, b2.readdatavalid}), 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 with the block out of reset.
  task automatic do_reset();
    mon_en = 1'b0;
    drive(idle(), idle(), 1'b1, 1'b0);
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) sb[i].delete();
    #1;
    check_held_in_reset(1'b1);
    check("rst_readdata", 0, {a1.readdata, a2.readdata}, 64'd0);
    check("rst_readdata", 1, {b1.readdata, b2.readdata}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_held_in_reset(1'b1);
    @(posedge clk); #1;
    check_held_in_reset(1'b0);
    mon_en = 1'b1;
  endtask

  // Monitor: pops and compares whenever a readdatavalid is presented.
  always @(negedge clk) begin
    logic [3:0]        rdv;
    logic [DATA_W-1:0] rdata [4];
    logic [DATA_W-1:0] mask;
    exp_t              e;
    if (mon_en) begin
      rdv = {b2.readdatavalid, b1.readdatavalid, a2.readdatavalid, a1.readdatavalid};
      rdata[0] = a1.readdata; rdata[1] = a2.readdata;
      rdata[2] = b1.readdata; rdata[3] = b2.readdata;
      if (!clken || reset_req) begin
        check("rdv_during_stall", 0, 64'(rdv), 64'd0);
      end else begin
        nsc++;
        for (int i = 0; i < 4; i++) begin
          if (rdv[i]) begin
            if (sb[i].size() == 0) begin
              check("stray_readdatavalid", i, 64'd1, 64'd0);
            end else begin
              e = sb[i].pop_front();
              check("read_latency", i, 64'(nsc), 64'(e.due));
              if (e.known != '0) begin
                for (int b = 0; b < BE_W; b++) mask[b*8 +: 8] = {8{e.known[b]}};
                check("readdata", i, 64'(rdata[i] & mask), 64'(e.data & mask));
              end
            end
          end else if (sb[i].size() != 0 && sb[i][0].due <= nsc) begin
            e = sb[i].pop_front();
            check("missing_readdatavalid", i, 64'd0, 64'd1);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_t        r [2];
    logic        ck, rq;
    int          op;
    for (int i = 0; i < DEPTH; i++) known_m[i] = '0;
    drive(idle(), idle(), 1'b1, 1'b0);
    @(posedge clk); #1;
    do_reset();

    // Preload.
    cycle(wr(10'h010, 32'h11223344, 4'hF), wr(10'h020, 32'hCAFEF00D, 4'hF), 1'b1, 1'b0);
    for (int i = 0; i < 8; i += 2)
      cycle(wr(10'(i), $urandom, 4'hF), wr(10'(i + 1), $urandom, 4'hF), 1'b1, 1'b0);

    // Partial byte write, then cross-port read.
    cycle(wr(10'h010, 32'hDEADBEEF, 4'b0101), idle(), 1'b1, 1'b0);
    cycle(idle(), rd(10'h010), 1'b1, 1'b0);
    idle_cycles(3);

    // Back-to-back reads on s1.
    for (int i = 0; i < 8; i++) cycle(rd(10'(i)), idle(), 1'b1, 1'b0);
    idle_cycles(3);

    // Same-address write collision; s2 holds its request one more cycle.
    cycle(wr(10'h3FF, 32'hA, 4'hF), wr(10'h3FF, 32'hB, 4'hF), 1'b1, 1'b0);
    cycle(idle(), wr(10'h3FF, 32'hB, 4'hF), 1'b1, 1'b0);
    cycle(wr(10'h001, 32'h1111_0001, 4'hF), wr(10'h002, 32'h2222_0002, 4'hF), 1'b1, 1'b0);
    cycle(rd(10'h3FF), rd(10'h001), 1'b1, 1'b0);
    cycle(rd(10'h002), idle(), 1'b1, 1'b0);
    idle_cycles(3);

    // Mixed-port read-during-write returns old data; re-read returns new.
    cycle(wr(10'h020, 32'h5, 4'hF), rd(10'h020), 1'b1, 1'b0);
    cycle(idle(), rd(10'h020), 1'b1, 1'b0);
    idle_cycles(3);

    // Reads frozen by clken=0, then by reset_req=1.
    cycle(rd(10'h010), rd(10'h3FF), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(rd(10'h020), idle(), 1'b0, 1'b0);
    idle_cycles(3);
    cycle(rd(10'h020), rd(10'h001), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(idle(), rd(10'h002), 1'b1, 1'b1);
    idle_cycles(3);

    // Reset in the middle of a read burst.
    for (int i = 0; i < 4; i++) cycle(rd(10'(i)), rd(10'(7 - i)), 1'b1, 1'b0);
    do_reset();
    idle_cycles(3);

    // Randomized traffic on a small address window to provoke collisions.
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        op        = $urandom_range(0, 3);
        r[p].cs   = ($urandom_range(0, 4) != 0);
        r[p].rd   = (op == 1) || (op == 3);
        r[p].wr   = (op == 2) || (op == 3);
        r[p].addr = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
        r[p].be   = 4'($urandom);
        r[p].wdata = $urandom;
      end
      ck = ($urandom_range(0, 9) != 0);
      rq = ($urandom_range(0, 14) == 0);
      cycle(r[0], r[1], ck, rq);
    end
    idle_cycles(5);

    for (int i = 0; i < 4; i++) check("scoreboard_drained", i, 64'(sb[i].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
